// File: rtl/leaf_cfg_pkg.sv
// Shared types and defaults for the leaf configuration sequencer.
// Holds the FSM state encoding, the valid-bit position and default parameters.
package leaf_cfg_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_PAYLOAD_W = 48;
  localparam int DEF_SETTLE_W  = 20;

  // The valid flag sits directly above the payload in a leaf word.
  localparam int LEAF_VALID_POS = DEF_PAYLOAD_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_KICK   = 3'd3,
    S_RUN    = 3'd4,
    S_FIN    = 3'd5
  } leaf_state_e;

endpackage

// File: rtl/leaf_cfg_table.sv
// DEPTH x PAYLOAD_W configuration register file.
// It has one synchronous write port and one combinational read port.
module leaf_cfg_table
  import leaf_cfg_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [PAYLOAD_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [PAYLOAD_W-1:0]       rdata
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; contents survive ap_rst_n
  // and a reset-free array maps onto plain flops or RAM without a clear tree.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/leaf_cfg_seq.sv
// Streams a table of config words into a BFT leaf, waits a settle gap,
// kicks the data-generator kernel and waits for it to finish.
// Optional feature macro: LEAF_CFG_SETTLE_EN (programmable settle gap).
module leaf_cfg_seq
  import leaf_cfg_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int SETTLE_W  = DEF_SETTLE_W
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         tbl_we,
  input  logic [$clog2(DEPTH)-1:0]     tbl_addr,
  input  logic [PAYLOAD_W-1:0]         tbl_wdata,
  input  logic [$clog2(DEPTH):0]       tbl_len,
  input  logic [SETTLE_W-1:0]          settle_cycles,
  input  logic                         start,
  output logic [PAYLOAD_W:0]           leaf_out,
  input  logic                         leaf_full_n,
  output logic                         kern_ap_start,
  input  logic                         kern_ap_done,
  output logic                         busy,
  output logic                         done,
  output logic                         err_len,
  output logic [$clog2(DEPTH):0]       words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  leaf_state_e          state;
  logic [AW-1:0]        idx;
  logic [LW-1:0]        len_q;
  logic                 kdone_seen;
  logic                 tbl_wr;
  logic                 len_bad;
  logic                 last_word;
  logic                 enter_settle;
  logic                 settle_zero;
  logic [AW-1:0]        rd_addr;
  logic [PAYLOAD_W-1:0] rd_data;
  logic [PAYLOAD_W-1:0] first_word;

  // The table is frozen whenever a sequence is in flight.
  assign tbl_wr       = tbl_we && (state == S_IDLE);
  assign len_bad      = tbl_len > LW'(DEPTH);
  assign last_word    = ({1'b0, idx} == len_q - 1'b1);
  assign enter_settle = ((state == S_IDLE) && start && !len_bad && (tbl_len == '0))
                     || ((state == S_LOAD) && leaf_full_n && last_word);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_addr = '0;
    if (state == S_LOAD) rd_addr = idx + 1'b1;
  end

  // A write to entry 0 in the start cycle must be seen by the first word.
  assign first_word = (tbl_wr && (tbl_addr == '0)) ? tbl_wdata : rd_data;

  leaf_cfg_table #(
    .DEPTH     (DEPTH),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_table (
    .clk   (ap_clk),
    .we    (tbl_wr),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef LEAF_CFG_SETTLE_EN
  logic [SETTLE_W-1:0] settle_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      settle_cnt <= '0;
    end else if (enter_settle) begin
      settle_cnt <= settle_cycles;
    end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  assign settle_zero = (settle_cnt == '0);
`else
  logic settle_unused;

  assign settle_zero   = 1'b1;
  assign settle_unused = ^{settle_cycles, enter_settle};
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= S_IDLE;
      leaf_out      <= '0;
      kern_ap_start <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err_len       <= 1'b0;
      words_sent    <= '0;
      idx           <= '0;
      len_q         <= '0;
      kdone_seen    <= 1'b0;
    end else begin
      kern_ap_start <= 1'b0;
      done          <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len_bad) begin
              err_len <= 1'b1;
            end else begin
              err_len    <= 1'b0;
              words_sent <= '0;
              len_q      <= tbl_len;
              idx        <= '0;
              busy       <= 1'b1;
              if (tbl_len == '0) begin
                state <= S_SETTLE;
              end else begin
                state    <= S_LOAD;
                leaf_out <= {1'b1, first_word};
              end
            end
          end
        end
        S_LOAD: begin
          // Without space at the leaf, idx and leaf_out simply hold.
          if (leaf_full_n) begin
            if (words_sent != len_q) words_sent <= words_sent + 1'b1;
            if (last_word) begin
              leaf_out <= '0;
              state    <= S_SETTLE;
            end else begin
              idx      <= idx + 1'b1;
              leaf_out <= {1'b1, rd_data};
            end
          end
        end
        S_SETTLE: begin
          if (settle_zero) begin
            kern_ap_start <= 1'b1;
            state         <= S_KICK;
          end
        end
        S_KICK: begin
          kdone_seen <= kern_ap_done;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (kern_ap_done || kdone_seen) begin
            kdone_seen <= 1'b0;
            done       <= 1'b1;
            state      <= S_FIN;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_cfg_seq.sv
// Directed self-checking bench for leaf_cfg_seq; expectations are hand-derived
// and adapt to whether LEAF_CFG_SETTLE_EN is defined.
module tb_leaf_cfg_seq;
  import leaf_cfg_pkg::*;

  localparam int DEPTH     = 16;
  localparam int PAYLOAD_W = 48;
  localparam int SETTLE_W  = 20;
  localparam int AW        = 4;
  localparam int LW        = 5;
`ifdef LEAF_CFG_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif

  logic                 ap_clk;
  logic                 ap_rst_n;
  logic                 tbl_we;
  logic [AW-1:0]        tbl_addr;
  logic [PAYLOAD_W-1:0] tbl_wdata;
  logic [LW-1:0]        tbl_len;
  logic [SETTLE_W-1:0]  settle_cycles;
  logic                 start;
  logic [PAYLOAD_W:0]   leaf_out;
  logic                 leaf_full_n;
  logic                 kern_ap_start;
  logic                 kern_ap_done;
  logic                 busy;
  logic                 done;
  logic                 err_len;
  logic [LW-1:0]        words_sent;

  logic [PAYLOAD_W-1:0] exp_tbl [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  leaf_cfg_seq #(
    .DEPTH     (DEPTH),
    .PAYLOAD_W (PAYLOAD_W),
    .SETTLE_W  (SETTLE_W)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .tbl_len       (tbl_len),
    .settle_cycles (settle_cycles),
    .start         (start),
    .leaf_out      (leaf_out),
    .leaf_full_n   (leaf_full_n),
    .kern_ap_start (kern_ap_start),
    .kern_ap_done  (kern_ap_done),
    .busy          (busy),
    .done          (done),
    .err_len       (err_len),
    .words_sent    (words_sent)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Observe one time unit after each rising edge; drive inputs at the same point.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [PAYLOAD_W-1:0] data);
    tbl_we    = 1'b1;
    tbl_addr  = AW'(addr);
    tbl_wdata = data;
    tick();
    tbl_we    = 1'b0;
    exp_tbl[addr] = data;
  endtask

  task automatic start_seq(input int len, input int settle);
    tbl_len       = LW'(len);
    settle_cycles = SETTLE_W'(settle);
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Follows a LOAD phase from the first displayed word; optional stall on one word.
  task automatic drive_load(input int n, input int stall_at, input int stall_len);
    int idx   = 0;
    int st    = 0;
    int guard = 0;
    while (idx < n && guard < 200) begin
      n_tests++;
      if (leaf_out !== {1'b1, exp_tbl[idx]}) begin
        n_fail++;
        $display("FAIL load_word[%0d]: got %h expected %h", idx, leaf_out, {1'b1, exp_tbl[idx]});
      end
      n_tests++;
      if (words_sent !== LW'(idx)) begin
        n_fail++;
        $display("FAIL load_count[%0d]: got %0d expected %0d", idx, words_sent, idx);
      end
      if (idx == stall_at && st < stall_len) begin
        leaf_full_n = 1'b0;
        st++;
      end else begin
        leaf_full_n = 1'b1;
        idx++;
      end
      tick();
      guard++;
    end
    leaf_full_n = 1'b1;
    n_tests++;
    if (guard !== n + stall_len) begin
      n_fail++;
      $display("FAIL load_cycles: got %0d expected %0d", guard, n + stall_len);
    end
    n_tests++;
    if (leaf_out[LEAF_VALID_POS] !== 1'b0 || words_sent !== LW'(n)) begin
      n_fail++;
      $display("FAIL load_end: got valid=%b sent=%0d expected valid=0 sent=%0d",
               leaf_out[LEAF_VALID_POS], words_sent, n);
    end
  endtask

  // Ticks until kern_ap_start is seen; reports cycles taken and any leaf valid seen.
  task automatic wait_kick(output int n, output int leaf_seen);
    n = 0;
    leaf_seen = 0;
    while (kern_ap_start !== 1'b1 && n < 200) begin
      if (leaf_out[LEAF_VALID_POS] !== 1'b0) leaf_seen++;
      tick();
      n++;
    end
  endtask

  // Starts from the KICK cycle; kernel reports done after `delay` RUN cycles.
  task automatic finish_kernel(input int delay, input int exp_ws);
    kern_ap_done = 1'b0;
    tick();
    n_tests++;
    if (kern_ap_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_width: got start=%b busy=%b expected start=0 busy=1", kern_ap_start, busy);
    end
    repeat (delay) begin
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL early_done: got %b expected 0", done);
      end
      tick();
    end
    kern_ap_done = 1'b1;
    tick();
    kern_ap_done = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b expected done=1 busy=1", done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
    tick();
    n_tests++;
    if (words_sent !== LW'(exp_ws)) begin
      n_fail++;
      $display("FAIL sent_hold: got %0d expected %0d", words_sent, exp_ws);
    end
  endtask

  task automatic test_reset();
    ap_rst_n      = 1'b1;
    tbl_we        = 1'b0;
    tbl_addr      = '0;
    tbl_wdata     = '0;
    tbl_len       = '0;
    settle_cycles = '0;
    start         = 1'b0;
    leaf_full_n   = 1'b1;
    kern_ap_done  = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({leaf_out, kern_ap_start, done, busy, err_len, words_sent} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got leaf=%h ks=%b done=%b busy=%b err=%b sent=%0d expected all 0",
               leaf_out, kern_ap_start, done, busy, err_len, words_sent);
    end
    @(posedge ap_clk);
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || leaf_out !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b leaf=%h expected 0 0", busy, leaf_out);
    end
  endtask

  task automatic test_two_words();
    int n, seen;
    write_word(0, 48'h0000_0000000a);
    write_word(1, 48'h0000_00002568);
    start_seq(2, 5);
    n_tests++;
    if (leaf_out !== 49'h1_0000_0000000a || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL two_word0: got %h busy=%b expected 1_0000_0000000a busy=1", leaf_out, busy);
    end
    tick();
    n_tests++;
    if (leaf_out !== 49'h1_0000_00002568) begin
      n_fail++;
      $display("FAIL two_word1: got %h expected 1_0000_00002568", leaf_out);
    end
    tick();
    n_tests++;
    if (leaf_out[LEAF_VALID_POS] !== 1'b0 || words_sent !== LW'(2)) begin
      n_fail++;
      $display("FAIL two_settle_entry: got valid=%b sent=%0d expected 0 2",
               leaf_out[LEAF_VALID_POS], words_sent);
    end
    // Settle 5 holds SETTLE six cycles, so the kick lands 7 cycles after the
    // last word; without the settle gap it lands 2 cycles after.
    wait_kick(n, seen);
    n_tests++;
    if (n !== (SETTLE_EN ? 6 : 1) || seen !== 0) begin
      n_fail++;
      $display("FAIL two_kick_delay: got %0d leaf=%0d expected %0d leaf=0", n, seen, SETTLE_EN ? 6 : 1);
    end
    finish_kernel(3, 2);
  endtask

  task automatic test_stall();
    int n, seen;
    for (int i = 0; i < DEPTH; i++) write_word(i, 48'h0000_1000_0000 + 48'(i) * 48'h111);
    start_seq(12, 3);
    drive_load(12, 4, 3);
    wait_kick(n, seen);
    n_tests++;
    if (n !== (SETTLE_EN ? 4 : 1) || seen !== 0) begin
      n_fail++;
      $display("FAIL stall_kick_delay: got %0d leaf=%0d expected %0d leaf=0", n, seen, SETTLE_EN ? 4 : 1);
    end
    finish_kernel(2, 12);
  endtask

  task automatic test_len_zero();
    int n, seen;
    start_seq(0, 0);
    n_tests++;
    if (busy !== 1'b1 || leaf_out[LEAF_VALID_POS] !== 1'b0 || words_sent !== '0) begin
      n_fail++;
      $display("FAIL zero_entry: got busy=%b valid=%b sent=%0d expected 1 0 0",
               busy, leaf_out[LEAF_VALID_POS], words_sent);
    end
    wait_kick(n, seen);
    n_tests++;
    if (n !== 1 || seen !== 0) begin
      n_fail++;
      $display("FAIL zero_kick_delay: got %0d leaf=%0d expected 1 leaf=0", n, seen);
    end
    // Completion reported in the KICK cycle itself must still finish the run.
    kern_ap_done = 1'b1;
    tick();
    kern_ap_done = 1'b0;
    n_tests++;
    if (done !== 1'b0 || kern_ap_start !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_run: got done=%b start=%b expected 0 0", done, kern_ap_start);
    end
    tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done_in_kick: got %b expected 1", done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_len_err();
    int n, seen;
    tbl_len = LW'(17);
    start   = 1'b1;
    tick();
    n_tests++;
    if (err_len !== 1'b1 || busy !== 1'b0 || leaf_out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: got err=%b busy=%b leaf=%h done=%b expected 1 0 0 0",
               err_len, busy, leaf_out, done);
    end
    tick();
    start = 1'b0;
    tick();
    n_tests++;
    if (err_len !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b busy=%b done=%b expected 1 0 0", err_len, busy, done);
    end
    start_seq(1, 0);
    n_tests++;
    if (err_len !== 1'b0 || busy !== 1'b1 || leaf_out !== {1'b1, exp_tbl[0]}) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b busy=%b leaf=%h expected 0 1 %h",
               err_len, busy, leaf_out, {1'b1, exp_tbl[0]});
    end
    tick();
    wait_kick(n, seen);
    n_tests++;
    if (n !== 1 || seen !== 0) begin
      n_fail++;
      $display("FAIL err_run_kick: got %0d leaf=%0d expected 1 leaf=0", n, seen);
    end
    finish_kernel(1, 1);
  endtask

  task automatic test_write_with_start();
    int n, seen;
    tbl_we    = 1'b1;
    tbl_addr  = '0;
    tbl_wdata = 48'hdead_beef_0123;
    exp_tbl[0] = 48'hdead_beef_0123;
    start_seq(2, 0);
    tbl_we = 1'b0;
    drive_load(2, -1, 0);
    wait_kick(n, seen);
    n_tests++;
    if (n !== 1 || seen !== 0) begin
      n_fail++;
      $display("FAIL wstart_kick: got %0d leaf=%0d expected 1 leaf=0", n, seen);
    end
    finish_kernel(0, 2);
  endtask

  task automatic test_reset_mid_load();
    int n, seen;
    start_seq(5, 0);
    repeat (3) tick();
    n_tests++;
    if (leaf_out !== {1'b1, exp_tbl[3]}) begin
      n_fail++;
      $display("FAIL rst_pre_word3: got %h expected %h", leaf_out, {1'b1, exp_tbl[3]});
    end
    #3 ap_rst_n = 1'b0;
    #1;
    n_tests++;
    if (leaf_out !== '0 || busy !== 1'b0 || words_sent !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_load: got leaf=%h busy=%b sent=%0d expected 0 0 0", leaf_out, busy, words_sent);
    end
    #2 ap_rst_n = 1'b1;
    tick();
    start_seq(5, 0);
    drive_load(5, -1, 0);
    wait_kick(n, seen);
    n_tests++;
    if (n !== 1 || seen !== 0) begin
      n_fail++;
      $display("FAIL rst_restart_kick: got %0d leaf=%0d expected 1 leaf=0", n, seen);
    end
    finish_kernel(1, 5);
  endtask

  task automatic test_busy_ignore();
    int n, seen;
    start_seq(2, 0);
    drive_load(2, -1, 0);
    wait_kick(n, seen);
    tick();
    tbl_we    = 1'b1;
    tbl_addr  = '0;
    tbl_wdata = 48'h5555_5555_5555;
    tbl_len   = LW'(3);
    start     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tbl_addr = AW'(c + 1);
      n_tests++;
      if (busy !== 1'b1 || leaf_out[LEAF_VALID_POS] !== 1'b0 || words_sent !== LW'(2) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ignore[%0d]: got busy=%b valid=%b sent=%0d done=%b expected 1 0 2 0",
                 c, busy, leaf_out[LEAF_VALID_POS], words_sent, done);
      end
    end
    tbl_we       = 1'b0;
    start        = 1'b0;
    kern_ap_done = 1'b1;
    tick();
    kern_ap_done = 1'b0;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done: got %b expected 1", done);
    end
    tick();
    tick();
    // Full-depth run reads back the table untouched by the ignored writes.
    start_seq(DEPTH, 0);
    drive_load(DEPTH, -1, 0);
    wait_kick(n, seen);
    n_tests++;
    if (n !== 1 || seen !== 0) begin
      n_fail++;
      $display("FAIL depth_kick: got %0d leaf=%0d expected 1 leaf=0", n, seen);
    end
    finish_kernel(0, DEPTH);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_stall();
    test_len_zero();
    test_len_err();
    test_write_with_start();
    test_reset_mid_load();
    test_busy_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
